if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch stage: owns the PC, issues word fetches to instruction memory over a req/ack handshake, and presents `if_pc`/`if_inst` to the IF/ID pipeline register. It is the producer for the IF/ID register. While no instruction is ready it raises `stallreq_if`, and the stall controller converts that into a bubble. Branch redirects from ID flush any held or in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 6: pipeline stall vector; only `stall[0]` (PC stage held) is used.
- `branch_en` input 1: one-cycle redirect pulse from ID.
- `branch_target` input 32: redirect PC, valid with `branch_en`.
- `mem_req` output 1: fetch request, level-held until acknowledged.
- `mem_addr` output 32: fetch address, stable while `mem_req` is high.
- `mem_ack` input 1: one-cycle pulse that completes the request; ignored when `mem_req` is low.
- `mem_rdata` input 32: instruction word, valid with `mem_ack`.
- `if_pc` output 32: PC of the presented instruction.
- `if_inst` output 32: presented instruction.
- `if_exc` output 1: misaligned-fetch flag for the presented slot (see Configuration).
- `stallreq_if` output 1: high whenever no valid instruction is presented.

## Operation
- States:
  - FETCH: request outstanding, result kept.
  - KILL: request outstanding, result discarded.
  - HOLD: instruction valid.
- Registers: `addr_q` (outstanding fetch address), `pc_q`/`inst_q`/`exc_q` (presented slot), `redir_q` (pending redirect target).
- `mem_req` = state is FETCH or KILL. `mem_addr` = `addr_q`.
- `if_pc` = `pc_q` and `if_inst` = `inst_q` in HOLD. Both are 0 in FETCH and KILL.
- `stallreq_if` = state is not HOLD.
- Transitions from FETCH:
  - `mem_ack` and no `branch_en`: `pc_q` <= `addr_q`, `inst_q` <= `mem_rdata`, go to HOLD.
  - `branch_en` and `mem_ack`: drop the data, `addr_q` <= `branch_target`, stay in FETCH. A new request is issued next cycle.
  - `branch_en` without `mem_ack`: `redir_q` <= `branch_target`, go to KILL.
- Transitions from KILL:
  - On `mem_ack`: drop the data, `addr_q` <= `redir_q`, go to FETCH.
  - A further `branch_en` in KILL overwrites `redir_q`. Last redirect wins.
- Transitions from HOLD:
  - `branch_en`: discard the held slot, `addr_q` <= `branch_target`, go to FETCH. This applies regardless of `stall`.
  - else `stall[0]`=0: slot consumed, `addr_q` <= `pc_q`+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go to FETCH.
  - else (`stall[0]`=1): hold everything unchanged.
- `branch_en` has priority over `stall[0]` and over normal sequencing.

## Timing
- Reset values: state FETCH, `addr_q`=`RESET_PC`. Outputs: `mem_req`=1, `mem_addr`=`RESET_PC`, `if_pc`=0, `if_inst`=0, `if_exc`=0, `stallreq_if`=1.
- Reset mid-request abandons the outstanding request. A late `mem_ack` arriving after reset is treated as the ack of the new `RESET_PC` request; memory must not ack across reset.
- `mem_ack` may arrive in the first cycle `mem_req` is high. With zero-wait memory, throughput is one instruction per 2 cycles (FETCH, then HOLD).
- Latency from `mem_ack` to instruction visible on `if_inst`: 1 cycle.
- Latency from `branch_en` to `mem_req` at the target:
  - 1 cycle from HOLD, or from FETCH with a coincident ack.
  - Otherwise the outstanding request's ack plus 1 cycle.
- `mem_addr` never changes while `mem_req`=1 and `mem_ack`=0.

## Configuration
- `IF_ALIGN_CHK_EN` defined: any new `addr_q` with bits [1:0] != 0 skips memory. The next state is HOLD with `pc_q`=`addr_q`, `inst_q`=0 and `exc_q`=1; `mem_req` stays low for that slot. `if_exc` = `exc_q` in HOLD and 0 elsewhere.
- `IF_ALIGN_CHK_EN` undefined: no check is made. Misaligned addresses are issued to memory as-is, and `if_exc` is tied to 0.

## Test plan
- Reset then zero-wait memory returning `mem_rdata`=32'h1000_0000+addr, with `stall`=0: sequential PCs 0,4,8 are presented every 2nd cycle with matching `if_inst`, and `stallreq_if` toggles 1,0.
- 3-cycle memory latency: `mem_addr` is held stable, `stallreq_if`=1 for 4 cycles, and the instruction appears 1 cycle after ack.
- HOLD at PC 8 with `stall[0]`=1 for 5 cycles: `if_pc`=8 and `if_inst` are unchanged and no `mem_req` is issued. When the stall is released, `mem_addr`=12 the next cycle.
- `branch_en` with target 32'h40 while in FETCH at addr 16, ack 2 cycles later: the data for 16 is never presented, `mem_addr`=32'h40 the cycle after the ack, and a second `branch_en` with target 32'h80 during KILL redirects to 32'h80 instead.
- `branch_en` with target 32'h100 coincident with `stall[0]`=1 in HOLD: the slot is flushed and `mem_addr`=32'h100 the next cycle. Separately, `rst` during an outstanding request gives `mem_addr`=`RESET_PC` next cycle.
- With `IF_ALIGN_CHK_EN` defined, `branch_target`=32'h42: `if_exc`=1, `if_pc`=32'h42, `if_inst`=0, and no `mem_req` for that address.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage; owns the PC, fetches over a req/ack port, presents a slot to IF/ID.
// Define IF_ALIGN_CHK_EN to trap misaligned fetch addresses locally instead of issuing them to memory.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_exc,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        KILL  = 2'd1,
        HOLD  = 2'd2
    } fetchState_t;

    fetchState_t r_state;
    fetchState_t w_nextState;
    logic [31:0] r_addrQ;
    logic [31:0] w_nextAddr;
    logic [31:0] r_pcQ;
    logic [31:0] w_nextPc;
    logic [31:0] r_instQ;
    logic [31:0] w_nextInst;
    logic [31:0] r_redirQ;
    logic [31:0] w_nextRedir;
    logic        w_newAddrValid;
    logic [31:0] w_newAddr;
`ifdef IF_ALIGN_CHK_EN
    logic        r_excQ;
    logic        w_nextExc;
`endif

    // Only the PC-stage bit of the stall vector matters to this stage.
    logic w_unusedStall;
    assign w_unusedStall = ^stall[5:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FETCH;
            r_addrQ  <= RESET_PC;
            r_pcQ    <= 32'd0;
            r_instQ  <= 32'd0;
            r_redirQ <= 32'd0;
`ifdef IF_ALIGN_CHK_EN
            r_excQ   <= 1'b0;
`endif
        end else begin
            r_state  <= w_nextState;
            r_addrQ  <= w_nextAddr;
            r_pcQ    <= w_nextPc;
            r_instQ  <= w_nextInst;
            r_redirQ <= w_nextRedir;
`ifdef IF_ALIGN_CHK_EN
            r_excQ   <= w_nextExc;
`endif
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextAddr     = r_addrQ;
        w_nextPc       = r_pcQ;
        w_nextInst     = r_instQ;
        w_nextRedir    = r_redirQ;
`ifdef IF_ALIGN_CHK_EN
        w_nextExc      = r_excQ;
`endif
        w_newAddrValid = 1'b0;
        w_newAddr      = r_addrQ;

        case (r_state)
            FETCH: begin
                if (branch_en) begin
                    if (mem_ack) begin
                        w_newAddrValid = 1'b1;
                        w_newAddr      = branch_target;
                    end else begin
                        w_nextRedir = branch_target;
                        w_nextState = KILL;
                    end
                end else if (mem_ack) begin
                    w_nextPc    = r_addrQ;
                    w_nextInst  = mem_rdata;
`ifdef IF_ALIGN_CHK_EN
                    w_nextExc   = 1'b0;
`endif
                    w_nextState = HOLD;
                end
            end
            KILL: begin
                // A redirect arriving with the ack still wins over the stored one.
                if (mem_ack) begin
                    w_newAddrValid = 1'b1;
                    w_newAddr      = branch_en ? branch_target : r_redirQ;
                end else if (branch_en) begin
                    w_nextRedir = branch_target;
                end
            end
            HOLD: begin
                if (branch_en) begin
                    w_newAddrValid = 1'b1;
                    w_newAddr      = branch_target;
                end else if (!stall[0]) begin
                    w_newAddrValid = 1'b1;
                    w_newAddr      = r_pcQ + 32'd4;
                end
            end
            default: begin
                w_nextState = FETCH;
            end
        endcase

        if (w_newAddrValid) begin
            w_nextAddr  = w_newAddr;
            w_nextState = FETCH;
`ifdef IF_ALIGN_CHK_EN
            // A misaligned target never reaches memory; it becomes a flagged empty slot.
            if (w_newAddr[1:0] != 2'b00) begin
                w_nextState = HOLD;
                w_nextPc    = w_newAddr;
                w_nextInst  = 32'd0;
                w_nextExc   = 1'b1;
            end
`endif
        end
    end

    assign mem_req     = (r_state != HOLD);
    assign mem_addr    = r_addrQ;
    assign stallreq_if = (r_state != HOLD);
    assign if_pc       = (r_state == HOLD) ? r_pcQ : 32'd0;
    assign if_inst     = (r_state == HOLD) ? r_instQ : 32'd0;
`ifdef IF_ALIGN_CHK_EN
    assign if_exc      = (r_state == HOLD) ? r_excQ : 1'b0;
`else
    assign if_exc      = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a small req/ack instruction memory returning 0x1000_0000 + address.
// Expectations follow the misaligned-fetch build selected by IF_ALIGN_CHK_EN.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_exc;
    logic        stallreq_if;

    int totalChecks = 0;
    int badChecks   = 0;
    int memLatency  = 0;
    int memCount    = 0;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_exc        (if_exc),
        .stallreq_if   (stallreq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers memLatency cycles after a request first appears; zero latency acks in the same cycle.
    always @(posedge clk) begin
        #2;
        if (rst || !mem_req) begin
            memCount  = 0;
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
        end else if (memCount >= memLatency) begin
            memCount  = 0;
            mem_ack   = 1'b1;
            mem_rdata = 32'h1000_0000 + mem_addr;
        end else begin
            memCount  = memCount + 1;
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks = totalChecks + 1;
        if (observed !== expected) begin
            badChecks = badChecks + 1;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic br, input logic [31:0] target, input logic stall0);
        branch_en     = br;
        branch_target = target;
        stall         = {5'b0, stall0};
    endtask

    // Advance one cycle; outputs are sampled well after the edge and after memory has responded.
    task automatic stepCycle();
        @(posedge clk);
        #3;
    endtask

    task automatic waitHold(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            if (stallreq_if == 1'b0) break;
            stepCycle();
        end
        checkOutput("holdReached", {31'b0, stallreq_if}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        checkOutput("rstMemReq", {31'b0, mem_req}, 32'd1);
        checkOutput("rstMemAddr", mem_addr, 32'h0);
        checkOutput("rstPc", if_pc, 32'h0);
        checkOutput("rstInst", if_inst, 32'h0);
        checkOutput("rstExc", {31'b0, if_exc}, 32'd0);
        checkOutput("rstStallreq", {31'b0, stallreq_if}, 32'd1);
        rst = 1'b0;

        $display("[TB] sequential zero-wait fetch");
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("seqAddr", mem_addr, 32'(4 * i));
            checkOutput("seqStallreqF", {31'b0, stallreq_if}, 32'd1);
            stepCycle();
            checkOutput("seqPc", if_pc, 32'(4 * i));
            checkOutput("seqInst", if_inst, 32'h1000_0000 + 32'(4 * i));
            checkOutput("seqStallreqH", {31'b0, stallreq_if}, 32'd0);
        end

        $display("[TB] stall in HOLD at pc 8");
        applyStimulus(1'b0, 32'd0, 1'b1);
        memLatency = 3;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("stallPc", if_pc, 32'h8);
            checkOutput("stallInst", if_inst, 32'h1000_0008);
            checkOutput("stallNoReq", {31'b0, mem_req}, 32'd0);
        end
        applyStimulus(1'b0, 32'd0, 1'b0);

        $display("[TB] three-cycle memory latency");
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("latAddr", mem_addr, 32'hC);
            checkOutput("latStallreq", {31'b0, stallreq_if}, 32'd1);
        end
        stepCycle();
        checkOutput("latPc", if_pc, 32'hC);
        checkOutput("latInst", if_inst, 32'h1000_000C);

        $display("[TB] branch during outstanding fetch");
        memLatency = 2;
        stepCycle();
        checkOutput("brFetchAddr", mem_addr, 32'h10);
        applyStimulus(1'b1, 32'h40, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("killAddr", mem_addr, 32'h10);
        checkOutput("killReq", {31'b0, mem_req}, 32'd1);
        checkOutput("killInst", if_inst, 32'h0);
        stepCycle();
        checkOutput("killAddrAck", mem_addr, 32'h10);
        checkOutput("killPc", if_pc, 32'h0);
        stepCycle();
        checkOutput("redirAddr", mem_addr, 32'h40);
        checkOutput("redirReq", {31'b0, mem_req}, 32'd1);
        checkOutput("redirInst", if_inst, 32'h0);
        waitHold(10);
        checkOutput("redirPc", if_pc, 32'h40);
        checkOutput("redirData", if_inst, 32'h1000_0040);

        $display("[TB] second branch during KILL");
        stepCycle();
        applyStimulus(1'b1, 32'h60, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'h80, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("kill2Addr", mem_addr, 32'h44);
        stepCycle();
        checkOutput("lastWinsAddr", mem_addr, 32'h80);
        waitHold(10);
        checkOutput("lastWinsPc", if_pc, 32'h80);
        checkOutput("lastWinsInst", if_inst, 32'h1000_0080);

        $display("[TB] branch with stall in HOLD, then reset mid-request");
        applyStimulus(1'b1, 32'h100, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("brStallAddr", mem_addr, 32'h100);
        checkOutput("brStallReq", {31'b0, mem_req}, 32'd1);
        checkOutput("brStallPc", if_pc, 32'h0);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("midRstAddr", mem_addr, 32'h0);
        checkOutput("midRstStallreq", {31'b0, stallreq_if}, 32'd1);
        waitHold(10);
        checkOutput("midRstPc", if_pc, 32'h0);
        checkOutput("midRstInst", if_inst, 32'h1000_0000);

        $display("[TB] branch coincident with ack, PC wrap");
        memLatency = 0;
        stepCycle();
        applyStimulus(1'b1, 32'h200, 1'b0);
        checkOutput("ackBrAddr", mem_addr, 32'h4);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("ackBrNewAddr", mem_addr, 32'h200);
        checkOutput("ackBrStallreq", {31'b0, stallreq_if}, 32'd1);
        stepCycle();
        checkOutput("ackBrPc", if_pc, 32'h200);
        checkOutput("ackBrInst", if_inst, 32'h1000_0200);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("wrapAddrTop", mem_addr, 32'hFFFF_FFFC);
        stepCycle();
        checkOutput("wrapPc", if_pc, 32'hFFFF_FFFC);
        checkOutput("wrapInst", if_inst, 32'h0FFF_FFFC);
        stepCycle();
        checkOutput("wrapAddrZero", mem_addr, 32'h0);

        $display("[TB] misaligned branch target");
        applyStimulus(1'b1, 32'h42, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
`ifdef IF_ALIGN_CHK_EN
        checkOutput("misExc", {31'b0, if_exc}, 32'd1);
        checkOutput("misPc", if_pc, 32'h42);
        checkOutput("misInst", if_inst, 32'h0);
        checkOutput("misNoReq", {31'b0, mem_req}, 32'd0);
        stepCycle();
        checkOutput("misNextPc", if_pc, 32'h46);
        checkOutput("misNextExc", {31'b0, if_exc}, 32'd1);
        checkOutput("misNextNoReq", {31'b0, mem_req}, 32'd0);
`else
        checkOutput("misReq", {31'b0, mem_req}, 32'd1);
        checkOutput("misAddr", mem_addr, 32'h42);
        checkOutput("misExc", {31'b0, if_exc}, 32'd0);
        stepCycle();
        checkOutput("misPc", if_pc, 32'h42);
        checkOutput("misInst", if_inst, 32'h1000_0042);
        checkOutput("misHoldExc", {31'b0, if_exc}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
